// File: rtl/sort4_pipe.sv
// sort4_pipe: pipelined 4-element sorter, three compare-exchange layers, one register stage each.
// Latency: 3 cycles from input transfer to out_valid, throughput 1 beat/cycle.
// Backpressure: all stages hold when out_valid & !out_ready; in_ready follows out_ready combinationally.
// Optional feature macro: SORT4_IDX_EN adds out_idx (original position of each sorted element).
module sort4_pipe #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WIDTH-1:0]   in_data,
    input  logic                 in_desc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic                 out_desc
`ifdef SORT4_IDX_EN
    ,
    output logic [7:0]           out_idx
`endif
);

    typedef logic [WIDTH-1:0] elem_t;
    typedef logic [1:0]       idx_t;

    // Strict greater-than on the full key width, signedness chosen at elaboration.
    function automatic logic key_gt(input elem_t a, input elem_t b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

    // Swap decision for a pair (lo position i, hi position j, i<j); equal keys never swap.
    function automatic logic must_swap(input elem_t e_lo, input elem_t e_hi, input logic desc);
        if (desc) begin
            return key_gt(e_hi, e_lo);
        end else begin
            return key_gt(e_lo, e_hi);
        end
    endfunction

    // Pipeline advances whenever the output register is empty or being drained.
    logic advance;

    elem_t in_e   [4];
    elem_t s1_e_d [4];
    elem_t s1_e_q [4];
    elem_t s2_e_d [4];
    elem_t s2_e_q [4];
    elem_t s3_e_d [4];
    elem_t s3_e_q [4];

    logic s1_vld_d, s1_vld_q, s1_desc_q;
    logic s2_vld_q, s2_desc_q;
    logic s3_vld_q, s3_desc_q;

    logic l1_sw02, l1_sw13;
    logic l2_sw01, l2_sw23;
    logic l3_sw12;

    // Flow control: a beat enters only when the pipe moves and reset is not active.
    always_comb begin
        advance  = !s3_vld_q | out_ready;
        in_ready = advance & !rst;
        s1_vld_d = in_valid & in_ready;
    end

    // Unpack the input bus into individual elements.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            in_e[k] = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Layer 1: compare-exchange pairs (0,2) and (1,3) using the incoming beat's mode.
    always_comb begin
        l1_sw02   = must_swap(in_e[0], in_e[2], in_desc);
        l1_sw13   = must_swap(in_e[1], in_e[3], in_desc);
        s1_e_d[0] = l1_sw02 ? in_e[2] : in_e[0];
        s1_e_d[2] = l1_sw02 ? in_e[0] : in_e[2];
        s1_e_d[1] = l1_sw13 ? in_e[3] : in_e[1];
        s1_e_d[3] = l1_sw13 ? in_e[1] : in_e[3];
    end

    // Layer 2: compare-exchange pairs (0,1) and (2,3) using the mode stored with the beat.
    always_comb begin
        l2_sw01   = must_swap(s1_e_q[0], s1_e_q[1], s1_desc_q);
        l2_sw23   = must_swap(s1_e_q[2], s1_e_q[3], s1_desc_q);
        s2_e_d[0] = l2_sw01 ? s1_e_q[1] : s1_e_q[0];
        s2_e_d[1] = l2_sw01 ? s1_e_q[0] : s1_e_q[1];
        s2_e_d[2] = l2_sw23 ? s1_e_q[3] : s1_e_q[2];
        s2_e_d[3] = l2_sw23 ? s1_e_q[2] : s1_e_q[3];
    end

    // Layer 3: final compare-exchange of the middle pair (1,2); ends are already in place.
    always_comb begin
        l3_sw12   = must_swap(s2_e_q[1], s2_e_q[2], s2_desc_q);
        s3_e_d[0] = s2_e_q[0];
        s3_e_d[1] = l3_sw12 ? s2_e_q[2] : s2_e_q[1];
        s3_e_d[2] = l3_sw12 ? s2_e_q[1] : s2_e_q[2];
        s3_e_d[3] = s2_e_q[3];
    end

    // Stage 1 register: captures layer-1 result, mode and valid of the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_desc_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                s1_e_q[k] <= '0;
            end
        end else if (advance) begin
            s1_vld_q  <= s1_vld_d;
            s1_desc_q <= in_desc;
            s1_e_q    <= s1_e_d;
        end
    end

    // Stage 2 register: layer-2 result travels with its beat's valid and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_desc_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                s2_e_q[k] <= '0;
            end
        end else if (advance) begin
            s2_vld_q  <= s1_vld_q;
            s2_desc_q <= s1_desc_q;
            s2_e_q    <= s2_e_d;
        end
    end

    // Stage 3 (output) register: holds the sorted beat stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_vld_q  <= 1'b0;
            s3_desc_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                s3_e_q[k] <= '0;
            end
        end else if (advance) begin
            s3_vld_q  <= s2_vld_q;
            s3_desc_q <= s2_desc_q;
            s3_e_q    <= s3_e_d;
        end
    end

    // Output packing, same element layout as the input bus.
    always_comb begin
        out_valid = s3_vld_q;
        out_desc  = s3_desc_q;
        out_data  = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*WIDTH +: WIDTH] = s3_e_q[k];
        end
    end

`ifdef SORT4_IDX_EN
    // Index tags follow the same swap decisions as the values they belong to.
    idx_t s1_i_d [4];
    idx_t s1_i_q [4];
    idx_t s2_i_d [4];
    idx_t s2_i_q [4];
    idx_t s3_i_d [4];
    idx_t s3_i_q [4];

    // Layer-wise index routing mirrors the value exchange network.
    always_comb begin
        s1_i_d[0] = l1_sw02 ? 2'd2 : 2'd0;
        s1_i_d[2] = l1_sw02 ? 2'd0 : 2'd2;
        s1_i_d[1] = l1_sw13 ? 2'd3 : 2'd1;
        s1_i_d[3] = l1_sw13 ? 2'd1 : 2'd3;
        s2_i_d[0] = l2_sw01 ? s1_i_q[1] : s1_i_q[0];
        s2_i_d[1] = l2_sw01 ? s1_i_q[0] : s1_i_q[1];
        s2_i_d[2] = l2_sw23 ? s1_i_q[3] : s1_i_q[2];
        s2_i_d[3] = l2_sw23 ? s1_i_q[2] : s1_i_q[3];
        s3_i_d[0] = s2_i_q[0];
        s3_i_d[1] = l3_sw12 ? s2_i_q[2] : s2_i_q[1];
        s3_i_d[2] = l3_sw12 ? s2_i_q[1] : s2_i_q[2];
        s3_i_d[3] = s2_i_q[3];
    end

    // Index registers share the enable and reset of the data stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                s1_i_q[k] <= '0;
                s2_i_q[k] <= '0;
                s3_i_q[k] <= '0;
            end
        end else if (advance) begin
            s1_i_q <= s1_i_d;
            s2_i_q <= s2_i_d;
            s3_i_q <= s3_i_d;
        end
    end

    // Pack output indices, element k at [2k +: 2].
    always_comb begin
        out_idx = '0;
        for (int k = 0; k < 4; k++) begin
            out_idx[2*k +: 2] = s3_i_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_sort4_pipe.sv
// tb_sort4_pipe: bench for sort4_pipe, unsigned and signed instances driven in parallel.
// Directed table vectors, back-to-back/stall/reset sequences, then randomized traffic.
// Scoreboard sorts each accepted beat with a plain reference sort and checks output order.
module tb_sort4_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_desc;
    logic        out_ready;

    logic        u_in_ready, u_out_valid, u_out_desc;
    logic [15:0] u_out_data;
    logic        s_in_ready, s_out_valid, s_out_desc;
    logic [15:0] s_out_data;
`ifdef SORT4_IDX_EN
    logic [7:0]  u_out_idx, s_out_idx;
`endif

    always #5 clk = ~clk;

    sort4_pipe #(.WIDTH(4), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_desc(in_desc), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_data(u_out_data), .out_desc(u_out_desc)
`ifdef SORT4_IDX_EN
        , .out_idx(u_out_idx)
`endif
    );

    sort4_pipe #(.WIDTH(4), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_desc(in_desc), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_desc(s_out_desc)
`ifdef SORT4_IDX_EN
        , .out_idx(s_out_idx)
`endif
    );

    int checks = 0;
    int errors = 0;
    int n_out_u = 0;
    int n_out_s = 0;
    logic [16:0] q_u[$];
    logic [16:0] q_s[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack4(input logic [3:0] e0, input logic [3:0] e1,
                                          input logic [3:0] e2, input logic [3:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [7:0] pidx(input logic [1:0] i0, input logic [1:0] i1,
                                        input logic [1:0] i2, input logic [1:0] i3);
        return {i3, i2, i1, i0};
    endfunction

    // Reference: order the four keys numerically, then lay them out asc or desc.
    function automatic logic [15:0] ref_sort(input logic [15:0] d, input logic desc, input bit sgn);
        int         key [4];
        logic [3:0] val [4];
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            val[i] = d[i*4 +: 4];
            key[i] = sgn ? int'($signed(val[i])) : int'(val[i]);
        end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3 - p; i++) begin
                if (key[i] > key[i+1]) begin
                    int t; logic [3:0] tv;
                    t = key[i]; key[i] = key[i+1]; key[i+1] = t;
                    tv = val[i]; val[i] = val[i+1]; val[i+1] = tv;
                end
            end
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = desc ? val[3-i] : val[i];
        end
        return r;
    endfunction

`ifdef SORT4_IDX_EN
    // Indices must form a permutation and point at the value that landed in each slot.
    function automatic bit idx_ok(input logic [15:0] din, input logic [15:0] dout, input logic [7:0] idx);
        logic [3:0] seen;
        seen = '0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = int'(idx[2*k +: 2]);
            seen[i] = 1'b1;
            if (dout[k*4 +: 4] !== din[i*4 +: 4]) return 1'b0;
        end
        return seen == 4'hF;
    endfunction
`endif

    // Scoreboard: record accepted beats, compare every presented output against the head.
    always @(negedge clk) begin
        if (rst) begin
            q_u.delete();
            q_s.delete();
        end else begin
            if (in_valid && u_in_ready) q_u.push_back({in_desc, in_data});
            if (in_valid && s_in_ready) q_s.push_back({in_desc, in_data});
            if (u_out_valid) begin
                if (q_u.size() == 0) begin
                    chk("uns_unexpected_out_valid", u_out_valid, 1'b0);
                end else begin
                    chk("uns_sb_data", u_out_data, ref_sort(q_u[0][15:0], q_u[0][16], 1'b0));
                    chk("uns_sb_desc", u_out_desc, q_u[0][16]);
`ifdef SORT4_IDX_EN
                    chk("uns_sb_idx", idx_ok(q_u[0][15:0], u_out_data, u_out_idx), 1'b1);
`endif
                    if (out_ready) begin
                        void'(q_u.pop_front());
                        n_out_u++;
                    end
                end
            end
            if (s_out_valid) begin
                if (q_s.size() == 0) begin
                    chk("sgn_unexpected_out_valid", s_out_valid, 1'b0);
                end else begin
                    chk("sgn_sb_data", s_out_data, ref_sort(q_s[0][15:0], q_s[0][16], 1'b1));
                    chk("sgn_sb_desc", s_out_desc, q_s[0][16]);
`ifdef SORT4_IDX_EN
                    chk("sgn_sb_idx", idx_ok(q_s[0][15:0], s_out_data, s_out_idx), 1'b1);
`endif
                    if (out_ready) begin
                        void'(q_s.pop_front());
                        n_out_s++;
                    end
                end
            end
        end
    end

    // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [15:0] d, input logic desc);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_desc  = desc;
        while (!acc) begin
            @(negedge clk);
            acc = u_in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 50) begin
                chk("send_accept_timeout", acc, 1'b1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q_u.size() != 0 || q_s.size() != 0) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(q_u.size() + q_s.size()), 32'd0);
    endtask

    typedef struct {
        logic [15:0] din;
        logic        desc;
        logic [15:0] exp_u;
        logic [15:0] exp_s;
        logic [7:0]  idx_u;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_u;
        vecs[0] = '{pack4(3,9,1,7),  1'b1, pack4(9,7,3,1),  pack4(7,3,1,9),  pidx(1,3,0,2)};
        vecs[1] = '{pack4(3,9,1,7),  1'b0, pack4(1,3,7,9),  pack4(9,1,3,7),  pidx(2,0,3,1)};
        vecs[2] = '{pack4(0,15,8,8), 1'b1, pack4(15,8,8,0), pack4(0,15,8,8), pidx(1,2,3,0)};
        vecs[3] = '{pack4(5,5,5,5),  1'b0, pack4(5,5,5,5),  pack4(5,5,5,5),  pidx(0,1,2,3)};
        vecs[4] = '{pack4(15,2,8,7), 1'b1, pack4(15,8,7,2), pack4(7,2,15,8), pidx(0,2,3,1)};
        vecs[5] = '{pack4(15,2,8,7), 1'b0, pack4(2,7,8,15), pack4(8,15,2,7), pidx(1,3,2,0)};
        vecs[6] = '{pack4(0,15,0,15),1'b0, pack4(0,0,15,15),pack4(15,15,0,0),pidx(0,2,1,3)};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_desc = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid_during", u_out_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", u_out_valid, 1'b0);
        chk("reset_out_data", u_out_data, 16'h0);
        chk("reset_out_desc", u_out_desc, 1'b0);
        chk("reset_in_ready", u_in_ready, 1'b1);
        chk("reset_in_ready_sgn", s_in_ready, 1'b1);
`ifdef SORT4_IDX_EN
        chk("reset_out_idx", u_out_idx, 8'h0);
`endif
        @(posedge clk);
        #1;

        // Table: single beats, exact 3-cycle latency and sorted result.
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].din, vecs[v].desc);
            @(negedge clk);
            chk($sformatf("vec%0d_lat1_valid", v), u_out_valid, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_lat2_valid", v), u_out_valid, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_lat3_valid", v), u_out_valid, 1'b1);
            chk($sformatf("vec%0d_uns_data", v), u_out_data, vecs[v].exp_u);
            chk($sformatf("vec%0d_sgn_data", v), s_out_data, vecs[v].exp_s);
            chk($sformatf("vec%0d_desc", v), u_out_desc, vecs[v].desc);
`ifdef SORT4_IDX_EN
            chk($sformatf("vec%0d_idx", v), u_out_idx, vecs[v].idx_u);
`endif
            @(posedge clk);
            #1;
        end
        drain();

        // Back-to-back beats with a mode change between them.
        send(vecs[1].din, vecs[1].desc);
        send(vecs[2].din, vecs[2].desc);
        @(negedge clk);
        chk("b2b_lat_valid", u_out_valid, 1'b0);
        @(negedge clk);
        chk("b2b_first_data", u_out_data, vecs[1].exp_u);
        chk("b2b_first_desc", u_out_desc, 1'b0);
        @(negedge clk);
        chk("b2b_second_valid", u_out_valid, 1'b1);
        chk("b2b_second_data", u_out_data, vecs[2].exp_u);
        chk("b2b_second_desc", u_out_desc, 1'b1);
        @(posedge clk);
        #1;
        drain();

        // Six back-to-back beats, consumer stalls in cycles 4-6.
        base_u = n_out_u;
        fork
            begin
                for (int b = 0; b < 6; b++) send(16'($urandom), 1'($urandom));
            end
            begin
                for (int c = 1; c <= 9; c++) begin
                    out_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
                    @(negedge clk);
                    chk($sformatf("stall_in_ready_c%0d", c), u_in_ready,
                        (c >= 4 && c <= 6) ? 1'b0 : 1'b1);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        chk("stall_beat_count", 32'(n_out_u - base_u), 32'd6);

        // Reset with two beats in flight, plus a beat offered during reset.
        send(16'h1234, 1'b0);
        send(16'hBEEF, 1'b1);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h5A5A; in_desc = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_low", u_in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_flush_out_valid", u_out_valid, 1'b0);
        chk("rst_flush_out_valid_sgn", s_out_valid, 1'b0);
        chk("rst_release_in_ready", u_in_ready, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("rst_no_ghost_c%0d", c), u_out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure, checked by the scoreboard.
        for (int i = 0; i < 800; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            in_desc   = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
